// File: rtl/dff_link_scheduler.sv
// Round-robin front end that shares one DEPTH-stage 1-bit shift chain between two requesters:
// serialises the granted word MSB-first and re-assembles it from the chain output.
module dff_link_scheduler #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             chain_in,
  input  logic             chain_out,
  output logic [WIDTH-1:0] rx_word,
  output logic             rx_src,
  output logic             rx_valid
);

  localparam int CW = (WIDTH + DEPTH > 1) ? $clog2(WIDTH + DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] CNT_CAP  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_TX   = CW'(WIDTH);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] tx_sr_reg;
  logic [WIDTH-1:0] rx_sr_reg;
  logic [WIDTH-1:0] rx_shift;
  logic             src_reg;
  logic             last_src_reg;
  logic [1:0]       grant_reg;
  logic [WIDTH-1:0] rx_word_reg;
  logic             rx_src_reg;
  logic             rx_valid_reg;

  logic start;
  logic winner;
  logic cnt_last;
  logic capture;

  assign start    = (state_reg == IDLE) && (req != 2'b00);
  // Contention goes to whoever did not win last time; a lone request always wins.
  assign winner   = (req == 2'b11) ? ~last_src_reg : req[1];
  assign cnt_last = (cnt_reg == CNT_LAST);
  assign capture  = (state_reg == XFER) && (cnt_reg >= CNT_CAP);

  // Receive shift view including the bit arriving this cycle.
  assign rx_shift[0] = chain_out;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_rx_shift
      assign rx_shift[gi] = rx_sr_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)    state_next = XFER;
      XFER:    if (cnt_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg == XFER);
    chain_in = (state_reg == XFER) && (cnt_reg < CNT_TX) && tx_sr_reg[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg      <= '0;
      tx_sr_reg    <= '0;
      rx_sr_reg    <= '0;
      src_reg      <= 1'b0;
      last_src_reg <= 1'b1;
      grant_reg    <= 2'b00;
      rx_word_reg  <= '0;
      rx_src_reg   <= 1'b0;
      rx_valid_reg <= 1'b0;
    end else begin
      grant_reg    <= 2'b00;
      rx_valid_reg <= 1'b0;
      if (start) begin
        tx_sr_reg    <= winner ? data1 : data0;
        src_reg      <= winner;
        last_src_reg <= winner;
        cnt_reg      <= '0;
        grant_reg    <= winner ? 2'b10 : 2'b01;
      end else if (state_reg == XFER) begin
        cnt_reg   <= cnt_reg + 1'b1;
        // Left shift keeps the next outgoing bit at the MSB.
        tx_sr_reg <= tx_sr_reg << 1;
        if (capture) rx_sr_reg <= rx_shift;
        if (cnt_last) begin
          rx_word_reg  <= rx_shift;
          rx_src_reg   <= src_reg;
          rx_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign grant    = grant_reg;
  assign rx_word  = rx_word_reg;
  assign rx_src   = rx_src_reg;
  assign rx_valid = rx_valid_reg;

endmodule
